// File: rtl/spi_slave_pkg.sv
// Shared constants for the serial burst register slave: FSM encoding, SPI mode codes
// and word-length helpers. SPI_WPARITY_EN appends one odd-parity bit to every write word.
package spi_slave_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RD   = 2'd3;

  // {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int word_len(input int data_bits);
`ifdef SPI_WPARITY_EN
    return data_bits + 1;
`else
    return data_bits;
`endif
  endfunction

  function automatic int hdr_rw_bit(input int hdr_bits);
    return hdr_bits - 1;
  endfunction

endpackage

// File: rtl/spi_burst_regslave_if.sv
// Off-chip serial pins of the register slave: SPI and AW daisy-chain lines plus
// the static mode straps. The master modport is the off-chip side.
interface spi_burst_regslave_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic sdi;
  logic pdi;
  logic sdo;
  logic ldb_n;
  logic mode_awmf;
  logic cpol;
  logic cpha;

  modport master (
    output sclk, cs_n, mosi, sdi, pdi, ldb_n, mode_awmf, cpol, cpha,
    input  miso, sdo
  );

  modport slave (
    input  sclk, cs_n, mosi, sdi, pdi, ldb_n, mode_awmf, cpol, cpha,
    output miso, sdo
  );
endinterface

// File: rtl/spi_edge_sync.sv
// Synchronises sclk, cs_n and ldb_n into clk and produces single-cycle edge pulses.
// sclk resets to the idle level given by cpol so reset release never looks like an edge.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpol,
  input  logic sclk,
  input  logic cs_n,
  input  logic ldb_n,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_low,
  output logic cs_fall,
  output logic cs_rise,
  output logic ldb_fall
);

  // bit SYNC_STAGES-1 is the synchronised value, bit SYNC_STAGES its previous sample
  logic [SYNC_STAGES:0] sclk_q;
  logic [SYNC_STAGES:0] cs_q;
  logic [SYNC_STAGES:0] ldb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= {(SYNC_STAGES + 1){cpol}};
      cs_q   <= '1;
      ldb_q  <= '1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
      cs_q   <= {cs_q[SYNC_STAGES-1:0], cs_n};
      ldb_q  <= {ldb_q[SYNC_STAGES-1:0], ldb_n};
    end
  end

  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign cs_low    = ~cs_q[SYNC_STAGES-1];
  assign cs_fall   = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES];
  assign cs_rise   = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
  assign ldb_fall  = ~ldb_q[SYNC_STAGES-1] & ldb_q[SYNC_STAGES];

endmodule

// File: rtl/spi_burst_regslave.sv
// Serial register slave with burst read/write, address auto-increment and a host read port.
// SPI_WPARITY_EN (optional) expects an odd-parity bit after each write word.
//
// state | meaning
// IDLE  | waiting for cs_n fall
// HDR   | shifting in R/W + start address
// WR    | collecting write words, commit each to regfile[ptr]
// RD    | shifting regfile[ptr] out, reload on every word boundary
module spi_burst_regslave
  import spi_slave_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int DATA_BITS   = 48,
  parameter int HDR_BITS    = 12,
  parameter int DEPTH       = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_burst_regslave_if.slave  bus,
  input  logic [ADDR_BITS-1:0] host_rd_addr,
  output logic [DATA_BITS-1:0] host_rd_data,
  output logic                 wr_pulse,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 frame_done,
  output logic                 err_pulse
);

  localparam int WORD_LEN = word_len(DATA_BITS);
  localparam int RW_BIT   = hdr_rw_bit(HDR_BITS);
  localparam int CNT_W    = $clog2(WORD_LEN + HDR_BITS);
  localparam logic [CNT_W-1:0]     HDR_LAST  = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0]     WORD_LAST = CNT_W'(WORD_LEN - 1);
  localparam logic [CNT_W-1:0]     DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [ADDR_BITS:0]   DEPTH_W   = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS-1:0] PTR_LAST  = ADDR_BITS'(DEPTH - 1);

  logic [DATA_BITS-1:0] regfile [DEPTH];

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [ADDR_BITS-1:0] ptr;
  logic                 oor;
  logic [WORD_LEN-2:0]  sh_in;
  logic [DATA_BITS-1:0] sh_out;
  logic                 out_bit;
  logic                 fwd_bit;

  logic sclk_rise, sclk_fall, cs_low, cs_fall, cs_rise, ldb_fall;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpol     (bus.cpol),
    .sclk     (bus.sclk),
    .cs_n     (bus.cs_n),
    .ldb_n    (bus.ldb_n),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_low   (cs_low),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .ldb_fall (ldb_fall)
  );

  logic                 sample_on_rise;
  always_comb begin
    sample_on_rise = 1'b0;
    case ({bus.cpol, bus.cpha})
      SPI_MODE0, SPI_MODE3: sample_on_rise = 1'b1;
      SPI_MODE1, SPI_MODE2: sample_on_rise = 1'b0;
    endcase
  end

  logic                 in_bit, frame_end, active, samp, shft;
  logic [ADDR_BITS-1:0] hdr_addr, ptr_next;
  logic                 hdr_rw, hdr_oor, word_end, par_ok, commit_en;
  logic [WORD_LEN-1:0]  word_full;
  logic [DATA_BITS-1:0] word_data;

  assign in_bit    = bus.mode_awmf ? (bus.sdi | bus.pdi) : bus.mosi;
  assign frame_end = cs_rise | (bus.mode_awmf & ldb_fall);
  assign active    = (state != ST_IDLE) & cs_low;
  // an sclk edge landing with frame end is dropped
  assign samp      = active & ~frame_end & (sample_on_rise ? sclk_rise : sclk_fall);
  assign shft      = active & ~frame_end & (sample_on_rise ? sclk_fall : sclk_rise);
  assign hdr_addr  = {sh_in[ADDR_BITS-2:0], in_bit};
  assign hdr_rw    = sh_in[RW_BIT-1];
  assign hdr_oor   = {1'b0, hdr_addr} >= DEPTH_W;
  assign ptr_next  = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  assign word_full = {sh_in, in_bit};
  assign word_data = word_full[WORD_LEN-1 -: DATA_BITS];
  assign word_end  = samp & (state == ST_WR) & (cnt == WORD_LAST);
`ifdef SPI_WPARITY_EN
  assign par_ok    = ^word_full;
`else
  assign par_ok    = 1'b1;
`endif
  assign commit_en = word_end & ~oor & par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ptr        <= '0;
      oor        <= 1'b0;
      sh_in      <= '0;
      sh_out     <= '0;
      out_bit    <= 1'b0;
      fwd_bit    <= 1'b0;
      wr_pulse   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      wr_pulse   <= commit_en;
      frame_done <= 1'b0;
      err_pulse  <= 1'b0;
      if (commit_en) begin
        wr_addr <= ptr;
        wr_data <= word_data;
      end
      if (frame_end && state != ST_IDLE) begin
        state      <= ST_IDLE;
        cnt        <= '0;
        out_bit    <= 1'b0;
        frame_done <= 1'b1;
      end else if (state == ST_IDLE) begin
        if (cs_fall) begin
          state <= ST_HDR;
          cnt   <= '0;
          oor   <= 1'b0;
        end
      end else begin
        if (samp) begin
          fwd_bit <= in_bit;
          sh_in   <= {sh_in[WORD_LEN-3:0], in_bit};
          if (state == ST_HDR) begin
            if (cnt == HDR_LAST) begin
              cnt       <= '0;
              ptr       <= hdr_addr;
              oor       <= hdr_oor;
              err_pulse <= hdr_oor;
              state     <= hdr_rw ? ST_WR : ST_RD;
              if (!hdr_rw) sh_out <= hdr_oor ? '0 : regfile[hdr_addr];
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (state == ST_WR) begin
            if (word_end) begin
              cnt       <= '0;
              ptr       <= ptr_next;
              err_pulse <= ~oor & ~par_ok;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        if (shft) begin
          if (state == ST_RD) begin
            out_bit <= sh_out[DATA_BITS-1];
            if (cnt == DATA_LAST) begin
              cnt    <= '0;
              ptr    <= ptr_next;
              sh_out <= oor ? '0 : regfile[ptr_next];
            end else begin
              cnt    <= cnt + 1'b1;
              sh_out <= {sh_out[DATA_BITS-2:0], 1'b0};
            end
          end else begin
            out_bit <= bus.mode_awmf ? fwd_bit : 1'b0;
          end
        end
      end
    end
  end

  // host read sees the pre-commit value when it collides with a serial write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regfile[i[ADDR_BITS-1:0]] <= '0;
      host_rd_data <= '0;
    end else begin
      if (commit_en) regfile[ptr] <= word_data;
      host_rd_data <= ({1'b0, host_rd_addr} < DEPTH_W) ? regfile[host_rd_addr] : '0;
    end
  end

  assign bus.miso = bus.mode_awmf ? 1'b0 : out_bit;
  assign bus.sdo  = bus.mode_awmf ? out_bit : 1'b0;

endmodule

// File: tb/tb_spi_burst_regslave.sv
// Directed bench for spi_burst_regslave (DEPTH=1000): burst writes/reads in all SPI modes,
// pointer wrap, OOR, partial frames, AW chain, mid-frame reset, and parity when SPI_WPARITY_EN is set.
module tb_spi_burst_regslave;
  localparam int AB   = 10;
  localparam int DB   = 48;
  localparam int DEP  = 1000;
  localparam int HALF = 80;

  localparam logic [DB-1:0] WA = 48'hA5A5_0123_4567;
  localparam logic [DB-1:0] WB = 48'h3C3C_89AB_CDEF;
  localparam logic [DB-1:0] WC = 48'hF00D_DEAD_BEEF;
  localparam logic [DB-1:0] WD = 48'h1234_5678_9ABC;
  localparam logic [DB-1:0] WE = 48'h8000_0000_0001;
  localparam logic [DB-1:0] WF = 48'hC0FF_EE00_7E57;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_burst_regslave_if bus();
  logic [AB-1:0] host_rd_addr;
  logic [DB-1:0] host_rd_data;
  logic          wr_pulse;
  logic [AB-1:0] wr_addr;
  logic [DB-1:0] wr_data;
  logic          frame_done;
  logic          err_pulse;

  spi_burst_regslave #(.ADDR_BITS(AB), .DATA_BITS(DB), .HDR_BITS(12), .DEPTH(DEP), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .host_rd_addr(host_rd_addr),
    .host_rd_data(host_rd_data),
    .wr_pulse    (wr_pulse),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .err_pulse   (err_pulse)
  );

  int vecs = 0;
  int miscompares = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [AB-1:0] wa_q[$];
  logic [DB-1:0] wd_q[$];
  int n_err = 0;
  int n_done = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_pulse) begin
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
      end
      if (err_pulse) n_err++;
      if (frame_done) n_done++;
    end
  end

  bit tx[$];
  bit rx[$];
  int wb, eb, db;
  logic [DB-1:0] hd;

  task automatic set_mode(input bit aw, input bit pol, input bit pha);
    bus.mode_awmf = aw;
    bus.cpol = pol;
    bus.cpha = pha;
    bus.sclk = pol;
    #100;
  endtask

  task automatic push_hdr(input bit rw, input int addr);
    logic [11:0] h;
    h = {rw, 1'b0, AB'(addr)};
    for (int i = 11; i >= 0; i--) tx.push_back(h[i]);
  endtask

  task automatic push_word(input logic [DB-1:0] w, input int n);
    for (int i = DB - 1; i >= DB - n; i--) tx.push_back(w[i]);
  endtask

  task automatic push_wword(input logic [DB-1:0] w);
    push_word(w, DB);
`ifdef SPI_WPARITY_EN
    tx.push_back(~^w);
`endif
  endtask

  task automatic spi_bit(input bit b, output bit o);
    if (!bus.cpha) begin
      bus.mosi = b; bus.sdi = b;
      #HALF;
      bus.sclk = ~bus.cpol;
      o = bus.mode_awmf ? bus.sdo : bus.miso;
      #HALF;
      bus.sclk = bus.cpol;
    end else begin
      bus.sclk = ~bus.cpol;
      bus.mosi = b; bus.sdi = b;
      #HALF;
      bus.sclk = bus.cpol;
      o = bus.mode_awmf ? bus.sdo : bus.miso;
      #HALF;
    end
  endtask

  task automatic run_frame(input bit end_ldb);
    bit o;
    rx.delete();
    bus.cs_n = 1'b0;
    #100;
    foreach (tx[i]) begin
      spi_bit(tx[i], o);
      rx.push_back(o);
    end
    #HALF;
    if (end_ldb) begin
      bus.ldb_n = 1'b0; #100;
      bus.ldb_n = 1'b1; #100;
    end else begin
      bus.cs_n = 1'b1; #200;
    end
  endtask

  function automatic logic [DB-1:0] rx_word(input int start);
    logic [DB-1:0] r = '0;
    for (int i = 0; i < DB; i++) r = {r[DB-2:0], (start + i < rx.size()) ? rx[start + i] : 1'b0};
    return r;
  endfunction

  task automatic host_read(input int addr, output logic [DB-1:0] d);
    host_rd_addr = AB'(addr);
    #30;
    d = host_rd_data;
  endtask

  task automatic chk_wr(input string tag, input int idx, input int addr, input logic [DB-1:0] data);
    if (idx >= wa_q.size()) chk_val({tag, "_missing"}, wa_q.size(), idx + 1);
    else begin
      chk_val({tag, "_addr"}, wa_q[idx], addr);
      chk_val({tag, "_data"}, wd_q[idx], data);
    end
  endtask

  task automatic mark();
    wb = wa_q.size(); eb = n_err; db = n_done;
    tx.delete();
  endtask

  initial begin
    logic [11:0] hz;
    logic [10:0] gf, ef;
    bit o;
    bus.cs_n = 1; bus.ldb_n = 1; bus.sclk = 0; bus.mosi = 0; bus.sdi = 0; bus.pdi = 0;
    bus.mode_awmf = 0; bus.cpol = 0; bus.cpha = 0;
    host_rd_addr = '0;
    #20;
    chk_val("rst_wr_pulse", wr_pulse, 0);
    chk_val("rst_frame_done", frame_done, 0);
    chk_val("rst_err_pulse", err_pulse, 0);
    chk_val("rst_miso", bus.miso, 0);
    chk_val("rst_sdo", bus.sdo, 0);
    chk_val("rst_host_data", host_rd_data, 0);
    #20 rst_n = 1;
    #100;

    // mode 0 burst write of three words at 5
    set_mode(0, 0, 0);
    mark(); push_hdr(1, 5); push_wword(WA); push_wword(WB); push_wword(WC);
    run_frame(0);
    chk_val("m0w_count", wa_q.size() - wb, 3);
    chk_wr("m0w_w0", wb, 5, WA);
    chk_wr("m0w_w1", wb + 1, 6, WB);
    chk_wr("m0w_w2", wb + 2, 7, WC);
    chk_val("m0w_err", n_err - eb, 0);
    chk_val("m0w_done", n_done - db, 1);
    host_read(6, hd); chk_val("host_rd6", hd, WB);

    // mode 3 burst read across three words
    set_mode(0, 1, 1);
    mark(); push_hdr(0, 5); push_word('0, DB); push_word('0, DB); push_word('0, DB);
    run_frame(0);
    hz = '0;
    for (int i = 0; i < 12; i++) hz = {hz[10:0], rx[i]};
    chk_val("m3r_hdr_miso", hz, 0);
    chk_val("m3r_w0", rx_word(12), WA);
    chk_val("m3r_w1", rx_word(60), WB);
    chk_val("m3r_w2", rx_word(108), WC);
    chk_val("m3r_nowr", wa_q.size() - wb, 0);
    chk_val("m3r_done", n_done - db, 1);

    // pointer wrap on write at the last implemented address
    set_mode(0, 0, 0);
    mark(); push_hdr(1, 999); push_wword(WD); push_wword(WE);
    run_frame(0);
    chk_val("wrap_count", wa_q.size() - wb, 2);
    chk_wr("wrap_w0", wb, 999, WD);
    chk_wr("wrap_w1", wb + 1, 0, WE);
    chk_val("wrap_err", n_err - eb, 0);
    host_read(0, hd); chk_val("host_rd0", hd, WE);

    // out-of-range write header
    mark(); push_hdr(1, 1000); push_wword(WF);
    run_frame(0);
    chk_val("oorw_nowr", wa_q.size() - wb, 0);
    chk_val("oorw_err", n_err - eb, 1);
    chk_val("oorw_done", n_done - db, 1);
    host_read(1000, hd); chk_val("host_rd_oor", hd, 0);

    // mode 1 read wraps 999 -> 0
    set_mode(0, 0, 1);
    mark(); push_hdr(0, 999); push_word('0, DB); push_word('0, DB);
    run_frame(0);
    chk_val("m1r_w0", rx_word(12), WD);
    chk_val("m1r_w1", rx_word(60), WE);
    chk_val("m1r_err", n_err - eb, 0);

    // mode 2 out-of-range read shifts zeros
    set_mode(0, 1, 0);
    mark(); push_hdr(0, 1000); push_word('0, DB);
    run_frame(0);
    chk_val("m2r_oor_data", rx_word(12), 0);
    chk_val("m2r_oor_err", n_err - eb, 1);

    // partial word and short header
    set_mode(0, 0, 0);
    mark(); push_hdr(1, 10); push_word(WF, 20);
    run_frame(0);
    chk_val("part_nowr", wa_q.size() - wb, 0);
    chk_val("part_done", n_done - db, 1);
    host_read(10, hd); chk_val("part_host10", hd, 0);
    mark(); tx.push_back(1); tx.push_back(0); tx.push_back(0); tx.push_back(0); tx.push_back(0);
    run_frame(0);
    chk_val("short_nowr", wa_q.size() - wb, 0);
    chk_val("short_err", n_err - eb, 0);
    chk_val("short_done", n_done - db, 1);

    // AW chain, ldb ends a one-word write
    set_mode(1, 0, 0);
    mark(); push_hdr(1, 20); push_wword(WF);
    run_frame(1);
    for (int k = 0; k < 11; k++) begin
      ef[10-k] = tx[k];
      gf[10-k] = rx[k+1];
    end
    chk_val("aw_sdo_fwd", gf, ef);
    chk_val("aw_count", wa_q.size() - wb, 1);
    chk_wr("aw_w0", wb, 20, WF);
    chk_val("aw_done", n_done - db, 1);
    bus.cs_n = 1'b1; #200;

`ifdef SPI_WPARITY_EN
    set_mode(0, 0, 0);
    mark(); push_hdr(1, 30);
    push_wword(WA);
    push_word(WB, DB); tx.push_back(^WB);
    push_wword(WC);
    run_frame(0);
    chk_val("par_count", wa_q.size() - wb, 2);
    chk_wr("par_w0", wb, 30, WA);
    chk_wr("par_w1", wb + 1, 32, WC);
    chk_val("par_err", n_err - eb, 1);
    host_read(31, hd); chk_val("par_host31", hd, 0);
`endif

    // reset in the middle of a write frame
    set_mode(0, 0, 0);
    mark(); push_hdr(1, 40); push_word(WF, 20);
    host_rd_addr = AB'(5);
    bus.cs_n = 1'b0; #100;
    foreach (tx[i]) spi_bit(tx[i], o);
    rst_n = 1'b0;
    #30;
    chk_val("midrst_wr_pulse", wr_pulse, 0);
    chk_val("midrst_host", host_rd_data, 0);
    bus.cs_n = 1'b1; #50;
    rst_n = 1'b1; #100;
    host_read(5, hd); chk_val("midrst_rf5", hd, 0);
    host_read(40, hd); chk_val("midrst_rf40", hd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
